serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial, LSB-first subtractor: computes A - B - iBorrowIn over WIDTH clocks
//  using a single full-subtractor cell and a borrow flip-flop.
//  It is the inverse counterpart of the ripple adder path in the FP normaliser.
//  Used for exponent difference and mantissa correction where area beats latency.
//  Start/done handshake; the result is held stable until the next operation completes.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//  iClk        in   1      clock; all state updates on rising edge
//  iRst        in   1      synchronous reset, active-high
//  iStart      in   1      request; sampled only when oBusy=0
//  iA          in   WIDTH  minuend; captured on the accepting edge
//  iB          in   WIDTH  subtrahend; captured on the accepting edge
//  iBorrowIn   in   1      initial borrow; captured on the accepting edge
//  oBusy       out  1      1 while an operation is in progress (RUN state)
//  oDone       out  1      1-cycle pulse: oDiff/oBorrowOut/oZero just updated
//  oDiff       out  WIDTH  (A - B - iBorrowIn) mod 2^WIDTH
//  oBorrowOut  out  1      final borrow: 1 iff A < B + iBorrowIn (unsigned)
//  oZero       out  1      1 iff oDiff == 0
// BEHAVIOUR
//  Reset: state IDLE; oBusy=0, oDone=0, oDiff=0, oBorrowOut=0, oZero=1.
//    Internal shift registers, borrow FF and counter are cleared.
//  FSM states: IDLE, RUN, DONE.
//  IDLE -> RUN on an edge with iStart=1.
//    On that edge: iA, iB and iBorrowIn are latched into rA, rB and rBr; cnt=0.
//  RUN, one edge per bit:
//    d   = rA[0] ^ rB[0] ^ rBr
//    br' = (~rA[0] & rB[0]) | (~rA[0] & rBr) | (rB[0] & rBr)
//    rA and rB shift right by 1; d enters the MSB of the result shift reg rS.
//    rBr <= br'; cnt <= cnt+1.
//  RUN -> DONE on the edge that processes bit WIDTH-1 (cnt == WIDTH-1).
//    On that edge: oDiff <= final rS; oBorrowOut <= br'; oZero <= (final rS == 0).
//  DONE: oDone=1 for exactly one cycle; oBusy=0.
//    Next edge -> IDLE, or -> RUN if iStart=1 (back-to-back accepted).
//  Latency: iStart accepted on edge k -> oDone high in the cycle after edge k+WIDTH.
//    Throughput: one result per WIDTH+1 cycles.
//  Output timing: oBusy=1 exactly in the WIDTH cycles after the accepting edge.
//    oDiff/oBorrowOut/oZero change only on the RUN->DONE edge.
//    Between operations they hold their last value.
//  iStart while oBusy=1: ignored. No queueing, no error flag.
//  iA/iB/iBorrowIn may change freely after the accepting edge.
//  Reset mid-operation: reset wins. The operation is aborted, no oDone pulse,
//    and all outputs return to their reset values.
//  Counter width: $clog2(WIDTH). All arithmetic is unsigned, modulo 2^WIDTH.
// TESTING
//  T1 W=8: A=0x5A, B=0x3C, Bin=0 -> oDone 8 cycles after accept.
//     oDiff=0x1E, oBorrowOut=0, oZero=0.
//  T2 W=8: A=0x3C, B=0x5A, Bin=0 -> oDiff=0xE2, oBorrowOut=1, oZero=0.
//  T3 W=8: A=0x00, B=0x00, Bin=1 -> oDiff=0xFF, oBorrowOut=1.
//     Also A=0xFF, B=0xFF, Bin=0 -> oDiff=0x00, oZero=1.
//  T4 Pulse iStart (A=0x01, B=0x02) while busy with T1's operands.
//     -> ignored; only one oDone, carrying T1's result.
//  T5 Assert iRst 3 cycles into RUN -> no oDone.
//     oBusy=0, oDiff=0, oBorrowOut=0, oZero=1 after the reset edge.
//  T6 Hold iStart=1 through DONE (back-to-back) -> second op accepted in DONE.
//     oDone pulses are 9 cycles apart. Random A/B/Bin sweep (W=2,8,32) vs reference model.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// Master issues operands and a start request; slave returns the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             iStart;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iBorrowIn;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oDiff;
    logic             oBorrowOut;
    logic             oZero;

    modport master (
        output iStart, iA, iB, iBorrowIn,
        input  oBusy, oDone, oDiff, oBorrowOut, oZero
    );

    modport slave (
        input  iStart, iA, iB, iBorrowIn,
        output oBusy, oDone, oDiff, oBorrowOut, oZero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: A - B - borrow_in over WIDTH clocks using one
// full-subtractor cell and a borrow flop. Result is held until the next op completes.
//
//   state  | meaning
//   S_IDLE | waiting for start; result outputs hold last value
//   S_RUN  | one operand bit consumed per clock (busy)
//   S_DONE | one-cycle done pulse; start here is accepted back-to-back
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
    logic               zero_q, zero_d;

    logic               bit_diff;
    logic               bit_borrow;
    logic [WIDTH-1:0]   s_shifted;

    assign bit_diff   = a_q[0] ^ b_q[0] ^ br_q;
    assign bit_borrow = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
    assign s_shifted  = {bit_diff, s_q[WIDTH-1:1]};

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        s_d          = s_q;
        br_d         = br_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.iStart) begin
                    state_d = S_RUN;
                    a_d     = bus.iA;
                    b_d     = bus.iB;
                    br_d    = bus.iBorrowIn;
                    s_d     = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                s_d   = s_shifted;
                br_d  = bit_borrow;
                cnt_d = cnt_q + CNT_W'(1);
                // Last bit: publish the freshly completed result on this edge.
                if (cnt_q == CNT_LAST) begin
                    state_d      = S_DONE;
                    diff_d       = s_shifted;
                    borrow_out_d = bit_borrow;
                    zero_d       = (s_shifted == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            s_q          <= '0;
            br_q         <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            s_q          <= s_d;
            br_q         <= br_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.oBusy      = busy_q;
    assign bus.oDone      = done_q;
    assign bus.oDiff      = diff_q;
    assign bus.oBorrowOut = borrow_out_q;
    assign bus.oZero      = zero_q;
endmodule
